// File: rtl/pattern_stream_gen_pkg.sv
// rtl/pattern_stream_gen_pkg.sv - shared defaults and FSM encodings for the pattern stream transmitter
package pattern_stream_gen_pkg;

  localparam int LEN_DEF   = 28;
  localparam int CNT_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/pattern_stream_gen.sv
// rtl/pattern_stream_gen.sv - serial x/TYPE frame transmitter with a one-deep load buffer
module pattern_stream_gen
  import pattern_stream_gen_pkg::*;
#(
  parameter int LEN   = LEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             load_type,
  input  logic [LEN-1:0]   load_bits,
  output logic             x,
  output logic             TYPE,
  output logic             frame_valid,
  output logic             frame_last,
  output logic [CNT_W-1:0] bit_idx
);

  state_t         state, state_nxt;
  logic           buf_full;
  logic           buf_type;
  logic [LEN-1:0] buf_bits;
  logic [LEN-1:0] shreg;
  logic           accept;

  assign load_ready = !buf_full;
  assign accept     = load_valid && !buf_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (buf_full) state_nxt = SETUP;
      SETUP:   state_nxt = SHIFT;
      SHIFT:   if (bit_idx == '0) state_nxt = buf_full ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The buffer is always full during SETUP, so draining it never races an accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_full    <= 1'b0;
      buf_type    <= 1'b0;
      buf_bits    <= '0;
      shreg       <= '0;
      x           <= 1'b0;
      TYPE        <= 1'b0;
      frame_valid <= 1'b0;
      frame_last  <= 1'b0;
      bit_idx     <= '0;
    end else begin
      if (state == SETUP) begin
        buf_full <= 1'b0;
      end else if (accept) begin
        buf_full <= 1'b1;
        buf_type <= load_type;
        buf_bits <= load_bits;
      end

      case (state)
        SETUP: begin
          TYPE        <= buf_type;
          x           <= buf_bits[LEN-1];
          shreg       <= {buf_bits[LEN-2:0], 1'b0};
          frame_valid <= 1'b1;
          frame_last  <= 1'b0;
          bit_idx     <= CNT_W'(LEN - 1);
        end
        SHIFT: begin
          if (bit_idx == '0) begin
            x           <= 1'b0;
            frame_valid <= 1'b0;
            frame_last  <= 1'b0;
          end else begin
            x          <= shreg[LEN-1];
            shreg      <= {shreg[LEN-2:0], 1'b0};
            bit_idx    <= bit_idx - CNT_W'(1);
            frame_last <= (bit_idx == CNT_W'(1));
          end
        end
        default: begin
          x           <= 1'b0;
          frame_valid <= 1'b0;
          frame_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
